// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: per-stage stall/flush enables,
// EX operand forwarding selects, and a sticky data-memory timeout flag.
module pipeline_hazard_ctrl #(
    parameter int RegAddrWidth = 5,
    parameter int MemTimeout   = 64,
    parameter int CntWidth     = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RegAddrWidth-1:0] id_rs1_addr,
    input  logic [RegAddrWidth-1:0] id_rs2_addr,
    input  logic                    id_rs1_used,
    input  logic                    id_rs2_used,
    input  logic [RegAddrWidth-1:0] ex_rd_addr,
    input  logic                    ex_wb_en,
    input  logic                    ex_is_load,
    input  logic [RegAddrWidth-1:0] mem_rd_addr,
    input  logic                    mem_wb_en,
    input  logic [RegAddrWidth-1:0] wb_rd_addr,
    input  logic                    wb_wb_en,
    input  logic                    ex_redirect,
    input  logic                    dmem_req,
    input  logic                    dmem_ack,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    stall_ex,
    output logic                    flush_if_id,
    output logic                    flush_id_ex,
    output logic                    flush_mem_wb,
    output logic [1:0]              fwd_rs1_sel,
    output logic [1:0]              fwd_rs2_sel,
    output logic                    mem_timeout
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_t;

    localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(MemTimeout);
    localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);

    state_t                state_reg, state_next;
    logic [CntWidth-1:0]   cnt_reg, cnt_next;
    logic                  mem_timeout_reg, mem_timeout_next;

    logic [RegAddrWidth-1:0] rs_addr [2];
    logic                    rs_used [2];
    logic [1:0]              fwd_sel [2];
    logic                    ex_hit  [2];
    logic                    lu;
    logic                    mw;

    assign rs_addr[0] = id_rs1_addr;
    assign rs_addr[1] = id_rs2_addr;
    assign rs_used[0] = id_rs1_used;
    assign rs_used[1] = id_rs2_used;

    // x0 is hardwired to zero, so a zero address never forwards or stalls.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic nonzero;
            assign nonzero = (rs_addr[gi] != '0);
            assign ex_hit[gi] = rs_used[gi] && nonzero && (ex_rd_addr == rs_addr[gi]);
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (nonzero && mem_wb_en && (mem_rd_addr == rs_addr[gi])) begin
                    fwd_sel[gi] = 2'b01;
                end else if (nonzero && wb_wb_en && (wb_rd_addr == rs_addr[gi])) begin
                    fwd_sel[gi] = 2'b10;
                end
            end
        end
    endgenerate

    assign lu = ex_is_load && ex_wb_en && (ex_hit[0] || ex_hit[1]);
    assign mw = dmem_req && !dmem_ack;

    assign fwd_rs1_sel = rst ? 2'b00 : fwd_sel[0];
    assign fwd_rs2_sel = rst ? 2'b00 : fwd_sel[1];
    assign mem_timeout = mem_timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            cnt_reg         <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    always_comb begin
        stall_if         = 1'b0;
        stall_id         = 1'b0;
        stall_ex         = 1'b0;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;
        flush_mem_wb     = 1'b0;
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        mem_timeout_next = mem_timeout_reg;

        if (rst) begin
            flush_if_id      = 1'b1;
            flush_id_ex      = 1'b1;
            flush_mem_wb     = 1'b1;
            state_next       = RUN;
            cnt_next         = '0;
            mem_timeout_next = 1'b0;
        end else if (mw) begin
            // Freeze the front of the pipe; a pending redirect stays held in EX.
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            stall_ex     = 1'b1;
            flush_mem_wb = 1'b1;
            state_next   = MEM_WAIT;
            if (state_reg == MEM_WAIT && cnt_reg != TimeoutCnt) begin
                cnt_next = cnt_reg + CntOne;
            end
            if (state_reg == MEM_WAIT && (cnt_reg + CntOne) >= TimeoutCnt) begin
                mem_timeout_next = 1'b1;
            end
        end else begin
            cnt_next   = '0;
            state_next = RUN;
            if (ex_redirect) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (lu && state_reg != LOAD_STALL) begin
                // One bubble is enough: the load then forwards from MEM.
                stall_if    = 1'b1;
                flush_id_ex = 1'b1;
                state_next  = LOAD_STALL;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected output vectors are queued
// when stimulus is applied and checked against the DUT on the following negedge.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic       id_rs1_used, id_rs2_used, ex_wb_en, ex_is_load;
    logic       mem_wb_en, wb_wb_en, ex_redirect, dmem_req, dmem_ack;
    logic       stall_if, stall_id, stall_ex;
    logic       flush_if_id, flush_id_ex, flush_mem_wb;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic       mem_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    logic [10:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .RegAddrWidth(5),
        .MemTimeout  (64),
        .CntWidth    (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd_addr  (ex_rd_addr),
        .ex_wb_en    (ex_wb_en),
        .ex_is_load  (ex_is_load),
        .mem_rd_addr (mem_rd_addr),
        .mem_wb_en   (mem_wb_en),
        .wb_rd_addr  (wb_rd_addr),
        .wb_wb_en    (wb_wb_en),
        .ex_redirect (ex_redirect),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .flush_mem_wb(flush_mem_wb),
        .fwd_rs1_sel (fwd_rs1_sel),
        .fwd_rs2_sel (fwd_rs2_sel),
        .mem_timeout (mem_timeout)
    );

    // Packed order: stall_if stall_id stall_ex flush_if_id flush_id_ex flush_mem_wb fwd1 fwd2 timeout
    function automatic logic [10:0] mk(input logic si, input logic sd, input logic se,
                                       input logic fi, input logic fe, input logic fm,
                                       input logic [1:0] f1, input logic [1:0] f2,
                                       input logic to);
        return {si, sd, se, fi, fe, fm, f1, f2, to};
    endfunction

    task automatic idle_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd_addr  = 5'd0; ex_wb_en    = 1'b0; ex_is_load  = 1'b0;
        mem_rd_addr = 5'd0; mem_wb_en   = 1'b0; wb_rd_addr  = 5'd0; wb_wb_en = 1'b0;
        ex_redirect = 1'b0; dmem_req    = 1'b0; dmem_ack    = 1'b0;
    endtask

    // Queue the expectation for the inputs just applied, then check on the negedge.
    task automatic step(input string tag, input logic [10:0] exp_v);
        logic [10:0] obs;
        logic [10:0] want;
        string       t;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(negedge clk);
        obs  = {stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, flush_mem_wb,
                fwd_rs1_sel, fwd_rs2_sel, mem_timeout};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        tests_run++;
        $display("[TB] %0t %s obs=%b exp=%b", $time, t, obs, want);
        assert (obs === want) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", t, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        // Reset forces flushes and zero forwarding even with a matching MEM writer.
        id_rs1_addr = 5'd3; id_rs1_used = 1'b1; mem_rd_addr = 5'd3; mem_wb_en = 1'b1;
        step("reset_c1", mk(0,0,0,1,1,1,2'b00,2'b00,0));
        step("reset_c2", mk(0,0,0,1,1,1,2'b00,2'b00,0));
        rst = 1'b0;
        idle_inputs();
        step("run_idle", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        // Load-use on rs2, then the load sits in MEM and forwards.
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd_addr = 5'd5;
        id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
        step("lu_stall", mk(1,0,0,0,1,0,2'b00,2'b00,0));
        ex_is_load = 1'b0; ex_wb_en = 1'b0; ex_rd_addr = 5'd0;
        mem_rd_addr = 5'd5; mem_wb_en = 1'b1;
        step("lu_fwd_mem", mk(0,0,0,0,0,0,2'b00,2'b01,0));

        // LOAD_STALL ignores a still-present load-use; back in RUN it stalls again.
        idle_inputs();
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd_addr = 5'd9;
        id_rs1_addr = 5'd9; id_rs1_used = 1'b1;
        step("lu2_stall", mk(1,0,0,0,1,0,2'b00,2'b00,0));
        step("lu2_in_ls", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        step("lu2_again", mk(1,0,0,0,1,0,2'b00,2'b00,0));

        // Forwarding priority and x0.
        idle_inputs();
        step("ls_drain", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        mem_rd_addr = 5'd7; mem_wb_en = 1'b1; wb_rd_addr = 5'd7; wb_wb_en = 1'b1;
        id_rs1_addr = 5'd7; id_rs1_used = 1'b1;
        step("fwd_mem_prio", mk(0,0,0,0,0,0,2'b01,2'b00,0));
        mem_wb_en = 1'b0; id_rs2_addr = 5'd7;
        step("fwd_wb_both", mk(0,0,0,0,0,0,2'b10,2'b10,0));
        mem_rd_addr = 5'd0; mem_wb_en = 1'b1; wb_rd_addr = 5'd0;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs2_used = 1'b1;
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd_addr = 5'd0;
        step("fwd_x0", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        // Memory wait for five cycles, ack on the sixth.
        idle_inputs();
        dmem_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("mw_%0d", i), mk(1,1,1,0,0,1,2'b00,2'b00,0));
        end
        dmem_ack = 1'b1;
        step("mw_ack", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle_inputs();
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd_addr = 5'd4;
        id_rs1_addr = 5'd4; id_rs1_used = 1'b1;
        step("mw_back_run", mk(1,0,0,0,1,0,2'b00,2'b00,0));
        idle_inputs();
        dmem_ack = 1'b1;
        step("ack_no_req", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        // Redirect beats load-use; FSM stays in RUN.
        idle_inputs();
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd_addr = 5'd6;
        id_rs2_addr = 5'd6; id_rs2_used = 1'b1; ex_redirect = 1'b1;
        step("redir_vs_lu", mk(0,0,0,1,1,0,2'b00,2'b00,0));
        ex_redirect = 1'b0;
        step("redir_stay_run", mk(1,0,0,0,1,0,2'b00,2'b00,0));

        // Memory wait beats redirect; redirect flush lands in the ack cycle.
        idle_inputs();
        step("ls_drain2", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        dmem_req = 1'b1; ex_redirect = 1'b1;
        step("mw_vs_redir_1", mk(1,1,1,0,0,1,2'b00,2'b00,0));
        step("mw_vs_redir_2", mk(1,1,1,0,0,1,2'b00,2'b00,0));
        dmem_ack = 1'b1;
        step("redir_at_ack", mk(0,0,0,1,1,0,2'b00,2'b00,0));

        // Timeout: entry cycle counts as 1; flag visible after 65 cycles in MEM_WAIT.
        idle_inputs();
        dmem_req = 1'b1;
        for (int j = 1; j <= 70; j++) begin
            step($sformatf("to_%0d", j), mk(1,1,1,0,0,1,2'b00,2'b00,(j >= 66)));
        end
        dmem_ack = 1'b1;
        step("to_ack_sticky", mk(0,0,0,0,0,0,2'b00,2'b00,1));
        idle_inputs();
        step("to_idle_sticky", mk(0,0,0,0,0,0,2'b00,2'b00,1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("to_in_reset", mk(0,0,0,1,1,1,2'b00,2'b00,0));
        rst = 1'b0;
        step("to_cleared", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
